// File: rtl/npu_pkg.sv
// ============================================================================
// Module  : npu_pkg
// Purpose : Shared types and frame-geometry constants for the pixel path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package npu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } pack_store_state_t;

    localparam int PIX_PER_FRAME = 182;
    localparam int PIX_PER_WORD  = 4;
    // The last word of a frame is partial, so round up.
    localparam int FRAME_WORDS   = (PIX_PER_FRAME + PIX_PER_WORD - 1) / PIX_PER_WORD;

endpackage : npu_pkg

`default_nettype wire

// File: rtl/pack_store_addr_ctr.sv
// ============================================================================
// Module  : pack_store_addr_ctr
// Purpose : Per-frame SRAM word counter with wrap, clear and last-word flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pack_store_addr_ctr
    import npu_pkg::*;
#(
    parameter int FRAME_WORDS = 46,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    logic [ADDR_W-1:0] r_count;

    assign last  = (r_count == ADDR_W'(FRAME_WORDS - 1));
    assign count = r_count;

    // Clear has priority so a frame restart never lands on a stale address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= last ? '0 : r_count + 1'b1;
        end
    end

endmodule : pack_store_addr_ctr

`default_nettype wire

// File: rtl/pack_store.sv
// ============================================================================
// Module  : pack_store
// Purpose : Writes packed pixel words to the feature-map SRAM and acks the
//           packer. Optional frame checksum: define PACK_STORE_CHKSUM_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pack_store
    import npu_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int FRAME_WORDS = npu_pkg::FRAME_WORDS,
    parameter int ADDR_W      = 6,
    parameter int WAIT_MAX    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pack_valid,
    input  logic [WORD_W-1:0] pack_data,
    input  logic              frame_start,
    output logic              save_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    output logic              frame_done,
    output logic              stall_err,
    output logic [WORD_W-1:0] frame_chksum
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    pack_store_state_t r_state;
    pack_store_state_t w_state_nxt;

    logic [WORD_W-1:0] r_wdata;
    logic [WAIT_W-1:0] r_wait;
    logic              r_stall;
    logic              r_frame_done;
    logic              r_abort;
    logic              r_last_wr;

    logic              w_accept;
    logic              w_grant;
    logic              w_abort_now;
    logic              w_fd_set;
    logic              w_ctr_clr;
    logic              w_ctr_inc;
    logic              w_ctr_last;
    logic [ADDR_W-1:0] w_count;

    assign w_accept    = (r_state == IDLE) && pack_valid;
    assign w_grant     = (r_state == WRITE) && mem_gnt;
    assign w_abort_now = r_abort || frame_start;
    assign w_fd_set    = (r_state == ACK) && r_last_wr && !w_abort_now;

    // A restart seen while a word is in flight only takes effect once that
    // word has been granted at its original address.
    assign w_ctr_clr = ((r_state == IDLE) && frame_start)
                    || (w_grant && w_abort_now)
                    || ((r_state == ACK) && frame_start);
    assign w_ctr_inc = w_grant && !w_abort_now;

    pack_store_addr_ctr #(
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_addr_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_ctr_clr),
        .inc   (w_ctr_inc),
        .count (w_count),
        .last  (w_ctr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        save_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (pack_valid) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                save_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata      <= '0;
            r_wait       <= '0;
            r_stall      <= 1'b0;
            r_frame_done <= 1'b0;
            r_abort      <= 1'b0;
            r_last_wr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wdata <= pack_data;
            end

            if (w_accept) begin
                r_wait <= '0;
            end else if ((r_state == WRITE) && !mem_gnt
                         && (r_wait != WAIT_W'(WAIT_MAX))) begin
                r_wait <= r_wait + 1'b1;
            end

            // Raised in the same cycle the wait count reaches WAIT_MAX.
            if ((r_state == WRITE) && !mem_gnt
                && (r_wait == WAIT_W'(WAIT_MAX - 1))) begin
                r_stall <= 1'b1;
            end

            if (r_state == WRITE) begin
                r_abort <= w_abort_now;
            end else begin
                r_abort <= 1'b0;
            end

            if (w_grant) begin
                r_last_wr <= w_ctr_last;
            end

            r_frame_done <= w_fd_set;
        end
    end

`ifdef PACK_STORE_CHKSUM_EN
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_chksum;

    // Words of an aborted frame never reach the next frame's checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_chksum <= '0;
        end else begin
            if (w_fd_set) begin
                r_chksum <= r_acc;
            end
            if (frame_start || w_fd_set) begin
                r_acc <= '0;
            end else if (w_grant && !r_abort) begin
                r_acc <= r_acc ^ r_wdata;
            end
        end
    end

    assign frame_chksum = r_chksum;
`else
    assign frame_chksum = '0;
`endif

    assign mem_addr   = w_count;
    assign mem_wdata  = r_wdata;
    assign frame_done = r_frame_done;
    assign stall_err  = r_stall;

endmodule : pack_store

`default_nettype wire

// File: doc/pack_store.md
# pack_store

Downstream neighbour of the pixel packer. Accepts each packed 32-bit pixel word, writes it to the feature-map SRAM at a sequential word address, and returns the one-cycle `save_done` acknowledge the packer waits on. It counts words per frame: 182 pixels give 46 words, the last one partial. It flags frame completion and flags SRAM grant stalls.

## Interface
Parameters:
- `WORD_W`, 32, packed word width
- `FRAME_WORDS`, 46, words per frame (ceil(182/4))
- `ADDR_W`, 6, SRAM word-address width; `FRAME_WORDS <= 2**ADDR_W`
- `WAIT_MAX`, 15, max cycles waiting for `mem_gnt` before `stall_err`

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `pack_valid`  in  1  packed word available; level, held until acknowledged
- `pack_data`  in  WORD_W  packed word; byte 0 = first pixel
- `frame_start`  in  1  pulse: restart word address at 0
- `save_done`  out  1  one-cycle acknowledge to packer
- `mem_req`  out  1  SRAM write request
- `mem_addr`  out  ADDR_W  SRAM word address
- `mem_wdata`  out  WORD_W  SRAM write data
- `mem_gnt`  in  1  SRAM accepts the request this cycle
- `frame_done`  out  1  one-cycle pulse after the last word of a frame is written
- `stall_err`  out  1  sticky: grant timeout occurred
- `frame_chksum`  out  WORD_W  XOR of all words in the finished frame (see Configuration)

## Operation
- FSM states:
  - IDLE: `pack_valid` -> latch `pack_data` into `mem_wdata`, go WRITE.
  - WRITE: `mem_req`=1, `mem_addr`=word counter. `mem_gnt` -> go ACK. Counter increments; at `FRAME_WORDS-1` it wraps to 0.
  - ACK: `save_done`=1 for exactly this cycle, then go IDLE.
- `pack_valid` is ignored outside IDLE. The packer drops `pack_valid` the cycle after ACK, so no word is double-captured.
- Wait counter: cleared on entry to WRITE, increments each WRITE cycle without grant. When it reaches `WAIT_MAX`, `stall_err` sets and stays set until `rst`. The request remains asserted and the transfer still completes on a later grant.
- `frame_done` pulses the cycle after the ACK of the word written at address `FRAME_WORDS-1`.
- `frame_start`:
  - In IDLE: clears the word counter the next cycle.
  - In WRITE/ACK: the current word completes at its original address. The counter is then forced to 0 instead of incrementing, and no `frame_done` is raised for the aborted frame.
- `mem_addr` and `mem_wdata` are registered and stable for the whole WRITE state. `mem_wdata` holds its value outside WRITE.

## Timing
- Reset values: state IDLE. `save_done`, `mem_req`, `frame_done` and `stall_err` are 0. `mem_addr`, `mem_wdata` and `frame_chksum` are 0. Word and wait counters are 0.
- `pack_valid` high in IDLE at cycle t:
  - `mem_req`=1 from t+1.
  - Grant at t+1 gives `save_done` at t+2 and IDLE at t+3.
  - Minimum 3 cycles per word.
- Grant delayed k cycles: `save_done` at t+2+k.
- `rst` mid-transfer: the next cycle is in reset state and no `save_done` is issued. The packer is reset together with this block.

## Configuration
- `PACK_STORE_CHKSUM_EN` defined:
  - A running XOR accumulates each granted word.
  - On the `frame_done` cycle, `frame_chksum` is updated to the final XOR and the accumulator clears.
  - `frame_start` also clears the accumulator.
- Not defined: no accumulator logic; `frame_chksum` is tied to 0.

## Structure
- Shared package `npu_pkg`:
  - FSM enum `pack_store_state_t` {IDLE, WRITE, ACK}
  - constants `PIX_PER_FRAME`=182, `PIX_PER_WORD`=4, `FRAME_WORDS`
- One natural sub-module, `pack_store_addr_ctr`: word counter with wrap, `frame_start` clear and last-word flag.

## Test plan
- Single word: `pack_data`=32'hDDCCBBAA at cycle 0 with grant held high -> `mem_req`=1 at cycle 1, `mem_addr`=0, `mem_wdata`=32'hDDCCBBAA, `save_done` at cycle 2 only.
- Full frame: 46 back-to-back words with grant always high -> addresses 0..45, `frame_done` once after address 45, next word at address 0.
- Grant stall: grant withheld 20 cycles with `WAIT_MAX`=15 -> `stall_err` sets after 15 cycles, write completes on grant, `stall_err` stays 1.
- `frame_start` during WRITE at address 10 -> word written at 10, next word at 0, no `frame_done`.
- Checksum (macro on): frame of words i (i=0..45) -> `frame_chksum`=XOR of 0..45 = 32'h1 on `frame_done`.
- `rst` asserted in WRITE -> all outputs 0 next cycle, no `save_done`.
